// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller.
//
// Holds the controller state encoding, the next-PC source encoding, the default
// address/instruction widths, the branch offset width, and a saturating
// increment helper for the RUN-cycle counter.

package fetch_pkg;

  // Default instruction ROM geometry
  localparam int unsigned DefaultAddrW = 16;
  localparam int unsigned DefaultInstW = 9;

  // Relative branch offset is a signed two's-complement byte
  localparam int unsigned BranchOffW = 8;

  // RUN-cycle counter width
  localparam int unsigned CycleCntW = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } fetch_state_e;

  // Source of the next program counter value
  typedef enum logic [1:0] {
    PcSeq    = 2'd0,
    PcJump   = 2'd1,
    PcBranch = 2'd2
  } pc_sel_e;

  // Counter increment that sticks at all-ones instead of rolling over
  function automatic logic [CycleCntW-1:0] sat_inc(input logic [CycleCntW-1:0] v);
    logic [CycleCntW-1:0] r;
    if (v == '1) begin
      r = v;
    end else begin
      r = v + 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/next_pc.sv
// Next program counter selection for the fetch controller.
//
// Purely combinational. Priority is jump > branch > sequential. All arithmetic
// is modulo 2^A, so the sequential step from all-ones wraps to zero and branch
// targets wrap in either direction.
//
// Ports:
//   pc_i         current program counter (address being fetched)
//   ir_addr_i    address of the instruction currently held for decode
//   jump_i       qualified absolute jump request
//   jump_addr_i  absolute jump target
//   branch_i     qualified taken-branch request
//   branch_off_i signed branch offset, relative to ir_addr_i
//   npc_o        selected next program counter
//   redirect_o   high when npc_o is a jump or branch target (not sequential)

module next_pc
  import fetch_pkg::*;
#(
  parameter int unsigned A = DefaultAddrW
) (
  input  logic [A-1:0]          pc_i,
  input  logic [A-1:0]          ir_addr_i,
  input  logic                  jump_i,
  input  logic [A-1:0]          jump_addr_i,
  input  logic                  branch_i,
  input  logic [BranchOffW-1:0] branch_off_i,
  output logic [A-1:0]          npc_o,
  output logic                  redirect_o
);

  pc_sel_e      pc_sel;
  logic [A-1:0] off_ext;
  logic [A-1:0] seq_pc;
  logic [A-1:0] branch_pc;

  // Signed size cast sign-extends the offset to the address width
  assign off_ext   = A'($signed(branch_off_i));
  assign seq_pc    = pc_i + 1'b1;
  // Branches are relative to the instruction that requested them, not to the
  // already-advanced fetch address
  assign branch_pc = ir_addr_i + off_ext;

  always_comb begin
    pc_sel = PcSeq;
    if (jump_i) begin
      pc_sel = PcJump;
    end else if (branch_i) begin
      pc_sel = PcBranch;
    end
  end

  always_comb begin
    npc_o = seq_pc;
    unique case (pc_sel)
      PcJump:   npc_o = jump_addr_i;
      PcBranch: npc_o = branch_pc;
      default:  npc_o = seq_pc;
    endcase
  end

  assign redirect_o = (pc_sel != PcSeq);

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller.
//
// Drives the address of an external combinational instruction ROM and registers
// the returned word for decode. Redirects (jump/branch) and halt requests come
// back from decode and apply only to a valid, non-squashed instruction. A
// taken redirect squashes the wrong-path fetch already in flight, costing one
// bubble. A downstream stall freezes all fetch state while the RUN-cycle
// counter keeps counting.
//
// Ports:
//   clk_i          clock, rising-edge
//   rst_i          asynchronous active-high reset
//   start_i        start/restart at address 0 (only in IDLE or DONE)
//   stall_i        downstream not ready, freeze fetch state
//   jump_en_i      absolute jump requested by inst_o
//   jump_addr_i    absolute jump target
//   branch_en_i    taken relative branch requested by inst_o
//   branch_off_i   signed branch offset relative to ir_addr_o
//   halt_req_i     halt requested by inst_o
//   inst_data_i    ROM read data for inst_address_o
//   inst_address_o ROM address (the program counter)
//   inst_o         registered instruction for decode
//   ir_addr_o      address inst_o was fetched from
//   inst_valid_o   inst_o holds a valid, non-squashed instruction
//   done_o         program halted
//   cycle_count_o  RUN cycles since the last start, saturating

module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned A = DefaultAddrW,
  parameter int unsigned W = DefaultInstW
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  stall_i,
  input  logic                  jump_en_i,
  input  logic [A-1:0]          jump_addr_i,
  input  logic                  branch_en_i,
  input  logic [BranchOffW-1:0] branch_off_i,
  input  logic                  halt_req_i,
  input  logic [W-1:0]          inst_data_i,
  output logic [A-1:0]          inst_address_o,
  output logic [W-1:0]          inst_o,
  output logic [A-1:0]          ir_addr_o,
  output logic                  inst_valid_o,
  output logic                  done_o,
  output logic [CycleCntW-1:0]  cycle_count_o
);

  fetch_state_e         state_q;
  logic [A-1:0]         pc_q;
  logic [W-1:0]         inst_q;
  logic [A-1:0]         ir_addr_q;
  logic                 inst_valid_q;
  logic                 done_q;
  logic [CycleCntW-1:0] cycle_q;

  logic                 halt_ok;
  logic                 jump_ok;
  logic                 branch_ok;
  logic [A-1:0]         npc;
  logic                 redirect;

  // Requests from decode are meaningless while inst_o is a bubble
  assign halt_ok   = halt_req_i  & inst_valid_q;
  assign jump_ok   = jump_en_i   & inst_valid_q;
  assign branch_ok = branch_en_i & inst_valid_q;

  next_pc #(
    .A (A)
  ) u_next_pc (
    .pc_i         (pc_q),
    .ir_addr_i    (ir_addr_q),
    .jump_i       (jump_ok),
    .jump_addr_i  (jump_addr_i),
    .branch_i     (branch_ok),
    .branch_off_i (branch_off_i),
    .npc_o        (npc),
    .redirect_o   (redirect)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      pc_q         <= '0;
      inst_q       <= '0;
      ir_addr_q    <= '0;
      inst_valid_q <= 1'b0;
      done_q       <= 1'b0;
      cycle_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start_i) begin
            state_q      <= StRun;
            pc_q         <= '0;
            inst_valid_q <= 1'b0;
            done_q       <= 1'b0;
            cycle_q      <= '0;
          end
        end

        StRun: begin
          // Counts every RUN cycle, stalled or not
          cycle_q <= sat_inc(cycle_q);
          if (!stall_i) begin
            if (halt_ok) begin
              // PC, inst_o and ir_addr_o are left where they are
              state_q      <= StDone;
              done_q       <= 1'b1;
              inst_valid_q <= 1'b0;
            end else begin
              pc_q <= npc;
              if (redirect) begin
                // The word on inst_data_i is the wrong path; drop it
                inst_valid_q <= 1'b0;
              end else begin
                inst_q       <= inst_data_i;
                ir_addr_q    <= pc_q;
                inst_valid_q <= 1'b1;
              end
            end
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign inst_address_o = pc_q;
  assign inst_o         = inst_q;
  assign ir_addr_o      = ir_addr_q;
  assign inst_valid_o   = inst_valid_q;
  assign done_o         = done_q;
  assign cycle_count_o  = cycle_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl. The ROM is modelled as ROM[a] = (a+1)
// truncated to 9 bits. Every fetch that should reach decode is pushed to a
// scoreboard queue as {ir_addr, inst}; each newly presented valid instruction
// is popped and compared.

module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stall;
  logic        jump_en;
  logic [15:0] jump_addr;
  logic        branch_en;
  logic [7:0]  branch_off;
  logic        halt_req;
  logic [8:0]  inst_data;
  logic [15:0] inst_address;
  logic [8:0]  inst;
  logic [15:0] ir_addr;
  logic        inst_valid;
  logic        done;
  logic [15:0] cycle_count;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [24:0] sb_q[$];

  always #5 clk = ~clk;

  function automatic logic [8:0] rom_f(input logic [15:0] a);
    logic [15:0] s;
    s = a + 16'd1;
    return s[8:0];
  endfunction

  assign inst_data = rom_f(inst_address);

  fetch_ctrl u_dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .stall_i        (stall),
    .jump_en_i      (jump_en),
    .jump_addr_i    (jump_addr),
    .branch_en_i    (branch_en),
    .branch_off_i   (branch_off),
    .halt_req_i     (halt_req),
    .inst_data_i    (inst_data),
    .inst_address_o (inst_address),
    .inst_o         (inst),
    .ir_addr_o      (ir_addr),
    .inst_valid_o   (inst_valid),
    .done_o         (done),
    .cycle_count_o  (cycle_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] addr, input logic [8:0] data);
    sb_q.push_back({addr, data});
  endtask

  // One clock; outputs sampled 1 time unit after the edge. A valid instruction
  // is new unless the edge was a stalled one.
  task automatic tick();
    logic        stalled;
    logic [24:0] exp;
    stalled = stall;
    @(posedge clk);
    #1;
    if (inst_valid && !stalled) begin
      if (sb_q.size() == 0) begin
        check("sb_pending", 32'(sb_q.size()), 32'd1);
      end else begin
        exp = sb_q.pop_front();
        check("sb_fetch", 32'({ir_addr, inst}), 32'(exp));
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    stall      = 1'b0;
    jump_en    = 1'b0;
    jump_addr  = 16'h0;
    branch_en  = 1'b0;
    branch_off = 8'h0;
    halt_req   = 1'b0;
    #2;
    check("rst_pc",    32'(inst_address), 32'h0);
    check("rst_inst",  32'(inst),         32'h0);
    check("rst_ir",    32'(ir_addr),      32'h0);
    check("rst_valid", 32'(inst_valid),   32'h0);
    check("rst_done",  32'(done),         32'h0);
    check("rst_cycle", 32'(cycle_count),  32'h0);
    tick();
    tick();
    rst = 1'b0;

    // Start and straight-line fetch
    start = 1'b1;
    tick();
    start = 1'b0;
    check("first_pc",    32'(inst_address), 32'h0);
    check("first_valid", 32'(inst_valid),   32'h0);
    check("first_cycle", 32'(cycle_count),  32'h0);
    push_exp(16'h0, 9'h001);
    push_exp(16'h1, 9'h002);
    push_exp(16'h2, 9'h003);
    push_exp(16'h3, 9'h004);
    repeat (4) tick();
    check("seq_cycle", 32'(cycle_count), 32'd4);

    // Start while running is ignored
    push_exp(16'h4, 9'h005);
    push_exp(16'h5, 9'h006);
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    check("run_start_pc", 32'(inst_address), 32'h6);

    // Backward branch from IRAddr 5
    branch_en  = 1'b1;
    branch_off = 8'hFE;
    tick();
    check("br_pc",    32'(inst_address), 32'h3);
    check("br_valid", 32'(inst_valid),   32'h0);
    branch_en = 1'b0;
    push_exp(16'h3, 9'h004);
    tick();

    // Jump beats branch; the redirect during the bubble is ignored
    jump_en    = 1'b1;
    jump_addr  = 16'h0040;
    branch_en  = 1'b1;
    branch_off = 8'h10;
    tick();
    check("jmp_pc",    32'(inst_address), 32'h40);
    check("jmp_valid", 32'(inst_valid),   32'h0);
    jump_addr = 16'h1234;
    push_exp(16'h40, 9'h041);
    tick();
    check("bubble_pc", 32'(inst_address), 32'h41);
    jump_en   = 1'b0;
    branch_en = 1'b0;
    check("pre_stall_cycle", 32'(cycle_count), 32'd10);

    // Stall with a jump pending: everything frozen, counter runs
    stall     = 1'b1;
    jump_en   = 1'b1;
    jump_addr = 16'h0080;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc",    32'(inst_address), 32'h41);
      check("stall_inst",  32'(inst),         32'h041);
      check("stall_ir",    32'(ir_addr),      32'h40);
      check("stall_valid", 32'(inst_valid),   32'h1);
    end
    stall   = 1'b0;
    jump_en = 1'b0;
    check("stall_cycle", 32'(cycle_count), 32'd13);
    push_exp(16'h41, 9'h042);
    tick();

    // Address wrap: sequential past FFFF, then branches across zero both ways
    jump_en   = 1'b1;
    jump_addr = 16'hFFFF;
    tick();
    check("top_pc", 32'(inst_address), 32'hFFFF);
    jump_en = 1'b0;
    push_exp(16'hFFFF, 9'h000);
    tick();
    check("wrap_pc", 32'(inst_address), 32'h0);
    branch_en  = 1'b1;
    branch_off = 8'h02;
    tick();
    check("br_fwd_wrap", 32'(inst_address), 32'h0001);
    branch_en = 1'b0;
    push_exp(16'h1, 9'h002);
    tick();
    branch_en  = 1'b1;
    branch_off = 8'h80;
    tick();
    check("br_back_wrap", 32'(inst_address), 32'hFF81);
    branch_en = 1'b0;
    push_exp(16'hFF81, 9'h182);
    tick();

    // Halt wins over a simultaneous jump; counter freezes in DONE
    halt_req  = 1'b1;
    jump_en   = 1'b1;
    jump_addr = 16'h0010;
    tick();
    check("halt_done",  32'(done),         32'h1);
    check("halt_valid", 32'(inst_valid),   32'h0);
    check("halt_pc",    32'(inst_address), 32'hFF82);
    check("halt_cycle", 32'(cycle_count),  32'd21);
    halt_req = 1'b0;
    jump_en  = 1'b0;
    tick();
    check("done_cycle", 32'(cycle_count), 32'd21);
    check("done_hold",  32'(done),        32'h1);

    // Restart from DONE
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_done",  32'(done),         32'h0);
    check("restart_pc",    32'(inst_address), 32'h0);
    check("restart_cycle", 32'(cycle_count),  32'h0);
    check("restart_valid", 32'(inst_valid),   32'h0);

    // Halt on a bubble is ignored
    halt_req = 1'b1;
    push_exp(16'h0, 9'h001);
    tick();
    check("halt_unq_done", 32'(done), 32'h0);
    halt_req = 1'b0;
    push_exp(16'h1, 9'h002);
    tick();

    // Asynchronous reset with a halt and jump pending
    jump_en   = 1'b1;
    jump_addr = 16'h0077;
    halt_req  = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("arst_pc",    32'(inst_address), 32'h0);
    check("arst_inst",  32'(inst),         32'h0);
    check("arst_ir",    32'(ir_addr),      32'h0);
    check("arst_valid", 32'(inst_valid),   32'h0);
    check("arst_done",  32'(done),         32'h0);
    check("arst_cycle", 32'(cycle_count),  32'h0);
    tick();
    check("arst_hold_pc",   32'(inst_address), 32'h0);
    check("arst_hold_done", 32'(done),         32'h0);
    jump_en  = 1'b0;
    halt_req = 1'b0;
    rst      = 1'b0;
    tick();
    tick();
    check("post_rst_pc",    32'(inst_address), 32'h0);
    check("post_rst_valid", 32'(inst_valid),   32'h0);
    check("post_rst_cycle", 32'(cycle_count),  32'h0);

    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter A, default 16, instruction address width; matches the instruction ROM address port.
REQ-002 Parameter W, default 9, instruction word width; matches the instruction ROM data port.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 Start  input  1  begin/restart execution at address 0; acted on only in IDLE or DONE.
REQ-006 Stall  input  1  downstream not ready; freeze fetch state.
REQ-007 JumpEn  input  1  absolute redirect requested by the instruction in Inst.
REQ-008 JumpAddr  input  A  absolute jump target.
REQ-009 BranchEn  input  1  taken relative branch requested by the instruction in Inst.
REQ-010 BranchOff  input  8  signed two's-complement branch offset.
REQ-011 HaltReq  input  1  halt requested by the instruction in Inst.
REQ-012 InstData  input  W  ROM read data; combinational function of InstAddress.
REQ-013 InstAddress  output  A  ROM address; equals PC register, combinational from state.
REQ-014 Inst  output  W  registered instruction for decode.
REQ-015 IRAddr  output  A  address from which Inst was fetched.
REQ-016 InstValid  output  1  Inst holds a valid, non-squashed instruction.
REQ-017 Done  output  1  program halted.
REQ-018 CycleCount  output  16  RUN cycles elapsed since last Start.

Function
REQ-019 States SHALL be IDLE, RUN, DONE.
REQ-020 IDLE: Start=1 -> RUN; PC<=0; CycleCount<=0; InstValid<=0.
REQ-021 RUN, Stall=1: PC, Inst, IRAddr, InstValid and state SHALL hold; CycleCount still increments.
REQ-022 RUN, Stall=0: redirect and halt inputs are qualified by InstValid=1; when unqualified, they are ignored.
REQ-023 Priority, Stall=0: qualified HaltReq > JumpEn > BranchEn > sequential.
REQ-024 Sequential: Inst<=InstData; IRAddr<=PC; InstValid<=1; PC<=PC+1.
REQ-025 Jump: PC<=JumpAddr; InstValid<=0, squashing the wrong-path fetch (one-cycle bubble).
REQ-026 Branch: PC<=IRAddr+sign_extend(BranchOff); InstValid<=0.
REQ-027 Halt: state<=DONE; Done<=1; InstValid<=0; PC holds.
REQ-028 PC arithmetic SHALL be modulo 2^A: 2^A-1 increments to 0, and branch targets wrap in both directions.
REQ-029 CycleCount increments once per cycle in RUN, saturates at 16'hFFFF and holds in IDLE/DONE.
REQ-030 DONE: Done stays 1; Start=1 -> RUN; PC<=0; Done<=0; CycleCount<=0.
REQ-031 Start in RUN SHALL be ignored.
REQ-032 First RUN cycle: InstAddress=0 with InstValid=0; the instruction at 0 appears in Inst one cycle later.

Reset
REQ-033 Reset=1 SHALL immediately force: state IDLE, PC=0, Inst=0, IRAddr=0, InstValid=0, Done=0, CycleCount=0.
REQ-034 Reset mid-RUN SHALL discard any pending redirect or halt; no output glitches to a non-reset value while Reset=1.

Structure
REQ-035 Package fetch_pkg SHALL hold the state enum (IDLE, RUN, DONE), the default A/W constants and the branch offset width (8).
REQ-036 Next-PC selection (sequential, jump or branch, with wrap) SHALL be one combinational sub-module, next_pc; fetch_ctrl keeps the FSM and registers.
REQ-037 The ROM is external; fetch_ctrl drives InstAddress and samples InstData.

Verification
REQ-038 Reset, then Start pulse with ROM[0..3]=9'h001..9'h004 and Stall=0 -> Inst/IRAddr=(001,0),(002,1),(003,2),(004,3) on cycles 2..5; InstValid=0 on cycle 1.
REQ-039 BranchEn=1, BranchOff=8'hFE, with valid Inst at IRAddr=5 -> next cycle InstValid=0 and PC=3; the following cycle Inst=ROM[3] with IRAddr=3.
REQ-040 JumpEn=1, JumpAddr=16'h0040 and BranchEn=1 in the same cycle -> PC=16'h0040 (jump wins), one bubble.
REQ-041 Stall=1 for 3 cycles, with JumpEn=1 asserted during the stall -> PC/Inst frozen and the jump ignored; CycleCount advances by 3.
REQ-042 PC=16'hFFFF sequential -> PC=0; BranchOff=8'h02 at IRAddr=16'hFFFF -> target 16'h0001.
REQ-043 HaltReq with InstValid=1 -> Done=1 next cycle and the CycleCount value is frozen; then Start -> Done=0, PC=0, CycleCount=0; Reset asserted mid-RUN -> all outputs 0 asynchronously.
